uni_shift_seq: RTL and testbench

- Command sequencer for the 8-bit universal shift register `uni_shift_8b`.
- Accepts a command {data, mode, count} over a valid/ready handshake.
- Drives the register's `ip`/`load`/`sh_ro_lt_rt` to load the data, then shift or rotate it `count` times.
- Returns the final register contents over a valid/ready response channel. It is the only master of the shift register.

---
 rtl/uni_shift_pkg.sv | 20 ++
 rtl/uni_shift_cnt.sv | 29 ++
 rtl/uni_shift_seq.sv | 106 ++++++++++
 tb/tb_uni_shift_seq.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/uni_shift_pkg.sv
// Shared definitions for the uni_shift command sequencer: state encoding, shift-register
// mode codes and default widths.
package uni_shift_pkg;

    localparam int unsigned DATA_W_DEF = 8;
    localparam int unsigned CNT_W_DEF  = 4;

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StLoad  = 2'd1,
        StShift = 2'd2,
        StDone  = 2'd3
    } seq_state_e;

    localparam logic [1:0] MODE_HOLD = 2'b00;
    localparam logic [1:0] MODE_SHR  = 2'b01;
    localparam logic [1:0] MODE_SHL  = 2'b10;
    localparam logic [1:0] MODE_ROR  = 2'b11;

endpackage

// File: rtl/uni_shift_cnt.sv
// Loadable down-counter with zero/one flags; saturates at zero.
module uni_shift_cnt #(
    parameter int unsigned CNT_W = 4
) (
    input  logic             clk,
    input  logic             rst_a,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    input  logic             dec,
    output logic             zero,
    output logic             one
);

    logic [CNT_W-1:0] cnt_q;

    always_ff @(posedge clk or negedge rst_a) begin
        if (!rst_a) begin
            cnt_q <= '0;
        end else if (load) begin
            cnt_q <= load_val;
        end else if (dec && !zero) begin
            cnt_q <= cnt_q - 1'b1;
        end
    end

    assign zero = (cnt_q == '0);
    assign one  = (cnt_q == CNT_W'(1));

endmodule

// File: rtl/uni_shift_seq.sv
// Command sequencer for the 8-bit universal shift register: load a value, then shift or
// rotate it a given number of times and return the result over a valid/ready channel.
module uni_shift_seq
    import uni_shift_pkg::*;
#(
    parameter int unsigned DATA_W = DATA_W_DEF,
    parameter int unsigned CNT_W  = CNT_W_DEF
) (
    input  logic              clk,
    input  logic              rst_a,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [DATA_W-1:0] cmd_data,
    input  logic [1:0]        cmd_mode,
    input  logic [CNT_W-1:0]  cmd_cnt,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_data,
    output logic              busy,
    output logic [DATA_W-1:0] sr_ip,
    output logic              sr_load,
    output logic [1:0]        sr_mode,
    input  logic [DATA_W-1:0] sr_op
);

    seq_state_e state_q;
    logic [1:0] mode_q;
    logic       cnt_load;
    logic       cnt_dec;
    logic       cnt_zero;
    logic       cnt_one;
    logic       accept;

    assign cmd_ready = (state_q == StIdle);
    assign busy      = (state_q != StIdle);
    assign accept    = cmd_ready && cmd_valid;
    assign cnt_load  = accept;
    assign cnt_dec   = (state_q == StShift);

    // Register holds in DONE, so its output is the stable result.
    assign rsp_data = sr_op;

    uni_shift_cnt #(
        .CNT_W (CNT_W)
    ) u_cnt (
        .clk      (clk),
        .rst_a    (rst_a),
        .load     (cnt_load),
        .load_val (cmd_cnt),
        .dec      (cnt_dec),
        .zero     (cnt_zero),
        .one      (cnt_one)
    );

    // sr_ip doubles as the latched command data: it is captured at acceptance and
    // must be held unchanged afterwards anyway.
    always_ff @(posedge clk or negedge rst_a) begin
        if (!rst_a) begin
            state_q   <= StIdle;
            mode_q    <= MODE_HOLD;
            rsp_valid <= 1'b0;
            sr_ip     <= '0;
            sr_load   <= 1'b0;
            sr_mode   <= MODE_HOLD;
        end else begin
            sr_load <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (cmd_valid) begin
                        mode_q  <= cmd_mode;
                        sr_ip   <= cmd_data;
                        sr_load <= 1'b1;
                        sr_mode <= MODE_HOLD;
                        state_q <= StLoad;
                    end
                end
                StLoad: begin
                    if (cnt_zero) begin
                        sr_mode   <= MODE_HOLD;
                        rsp_valid <= 1'b1;
                        state_q   <= StDone;
                    end else begin
                        sr_mode <= mode_q;
                        state_q <= StShift;
                    end
                end
                StShift: begin
                    if (cnt_one) begin
                        sr_mode   <= MODE_HOLD;
                        rsp_valid <= 1'b1;
                        state_q   <= StDone;
                    end
                end
                StDone: begin
                    sr_mode <= MODE_HOLD;
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        state_q   <= StIdle;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_uni_shift_seq.sv
// Directed bench for uni_shift_seq with a behavioural 8-bit universal shift register.
module tb_uni_shift_seq;

    localparam int unsigned DW = 8;
    localparam int unsigned CW = 4;

    logic          clk;
    logic          rst_a;
    logic          cmd_valid;
    logic          cmd_ready;
    logic [DW-1:0] cmd_data;
    logic [1:0]    cmd_mode;
    logic [CW-1:0] cmd_cnt;
    logic          rsp_valid;
    logic          rsp_ready;
    logic [DW-1:0] rsp_data;
    logic          busy;
    logic [DW-1:0] sr_ip;
    logic          sr_load;
    logic [1:0]    sr_mode;
    logic [DW-1:0] sr_q;

    int n_cmp;
    int n_err;

    uni_shift_seq #(
        .DATA_W (DW),
        .CNT_W  (CW)
    ) dut (
        .clk       (clk),
        .rst_a     (rst_a),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_data  (cmd_data),
        .cmd_mode  (cmd_mode),
        .cmd_cnt   (cmd_cnt),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_data  (rsp_data),
        .busy      (busy),
        .sr_ip     (sr_ip),
        .sr_load   (sr_load),
        .sr_mode   (sr_mode),
        .sr_op     (sr_q)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Shift register model: load has priority, then hold/shr/shl/ror.
    always_ff @(posedge clk or negedge rst_a) begin
        if (!rst_a) begin
            sr_q <= '0;
        end else if (sr_load) begin
            sr_q <= sr_ip;
        end else begin
            case (sr_mode)
                2'b01:   sr_q <= {1'b0, sr_q[DW-1:1]};
                2'b10:   sr_q <= {sr_q[DW-2:0], 1'b0};
                2'b11:   sr_q <= {sr_q[0], sr_q[DW-1:1]};
                default: sr_q <= sr_q;
            endcase
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [7:0] d, input logic [1:0] m, input logic [3:0] c);
        cmd_valid = 1'b1;
        cmd_data  = d;
        cmd_mode  = m;
        cmd_cnt   = c;
        tick();
        cmd_valid = 1'b0;
        check("load_pulse", {31'd0, sr_load}, 32'd1);
        check("load_ip", {24'd0, sr_ip}, {24'd0, d});
    endtask

    task automatic wait_rsp(input string tag, input int exp_edges, input logic [7:0] exp_data);
        int n;
        n = 0;
        while (!rsp_valid && n < 40) begin
            tick();
            n++;
        end
        check({tag, "_lat"}, n, exp_edges);
        check({tag, "_data"}, {24'd0, rsp_data}, {24'd0, exp_data});
    endtask

    task automatic handshake(input string tag);
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        check({tag, "_idle"}, {30'd0, busy, rsp_valid}, 32'd0);
    endtask

    task automatic run(input string tag, input logic [7:0] d, input logic [1:0] m,
                       input logic [3:0] c, input logic [7:0] exp_data);
        send(d, m, c);
        wait_rsp(tag, int'(c) + 1, exp_data);
        handshake(tag);
    endtask

    initial begin
        n_cmp     = 0;
        n_err     = 0;
        rst_a     = 1'b0;
        cmd_valid = 1'b0;
        cmd_data  = '0;
        cmd_mode  = '0;
        cmd_cnt   = '0;
        rsp_ready = 1'b0;
        #3;
        check("rst_outs", {sr_ip, 3'd0, sr_load, sr_mode, rsp_valid, busy}, 32'd0);
        check("rst_ready", {31'd0, cmd_ready}, 32'd1);
        #9;
        rst_a = 1'b1;
        tick();

        // Reset in the second shift cycle discards the command.
        send(8'hCC, 2'b01, 4'd5);
        tick();
        check("shift_mode", {30'd0, sr_mode}, 32'd1);
        tick();
        #2;
        rst_a = 1'b0;
        #1;
        check("mid_rst_outs", {sr_ip, 3'd0, sr_load, sr_mode, rsp_valid, busy}, 32'd0);
        check("mid_rst_ready", {31'd0, cmd_ready}, 32'd1);
        rst_a = 1'b1;
        tick();
        check("post_rst_norsp", {31'd0, rsp_valid}, 32'd0);
        run("after_rst", 8'h0F, 2'b10, 4'd1, 8'h1E);

        run("shr1", 8'hCC, 2'b01, 4'd1, 8'h66);
        run("shl2", 8'hF0, 2'b10, 4'd2, 8'hC0);
        run("ror1", 8'h81, 2'b11, 4'd1, 8'hC0);
        run("ror8", 8'hAD, 2'b11, 4'd8, 8'hAD);
        run("cnt0", 8'hCC, 2'b01, 4'd0, 8'hCC);
        run("shl9", 8'hFF, 2'b10, 4'd9, 8'h00);
        run("hold3", 8'h5A, 2'b00, 4'd3, 8'h5A);
        run("ror15", 8'h01, 2'b11, 4'd15, 8'h02);

        // Backpressure in DONE.
        send(8'hCC, 2'b01, 4'd1);
        wait_rsp("bp", 2, 8'h66);
        for (int i = 0; i < 4; i++) begin
            tick();
            check("bp_hold", {rsp_data, 6'd0, cmd_ready, busy, 7'd0, rsp_valid, 8'd0},
                  {8'h66, 6'd0, 1'b0, 1'b1, 7'd0, 1'b1, 8'd0});
        end
        handshake("bp");
        check("bp_ready", {31'd0, cmd_ready}, 32'd1);

        // Commands offered while busy are ignored.
        send(8'h3C, 2'b10, 4'd3);
        tick();
        cmd_valid = 1'b1;
        cmd_data  = 8'hFF;
        cmd_mode  = 2'b01;
        cmd_cnt   = 4'd0;
        check("busy_noready", {31'd0, cmd_ready}, 32'd0);
        tick();
        cmd_valid = 1'b0;
        tick();
        cmd_valid = 1'b1;
        cmd_data  = 8'h11;
        tick();
        cmd_valid = 1'b0;
        check("busy_rsp", {23'd0, rsp_valid, rsp_data}, {23'd0, 1'b1, 8'hE0});
        check("busy_ip", {24'd0, sr_ip}, 32'h3C);

        // Back-to-back: next command accepted one cycle after the response handshake.
        rsp_ready = 1'b1;
        cmd_valid = 1'b1;
        cmd_data  = 8'h81;
        cmd_mode  = 2'b01;
        cmd_cnt   = 4'd2;
        tick();
        rsp_ready = 1'b0;
        check("b2b_idle", {29'd0, cmd_ready, sr_load, rsp_valid}, 32'b100);
        tick();
        cmd_valid = 1'b0;
        check("b2b_accept", {22'd0, cmd_ready, sr_load, sr_ip}, {22'd0, 1'b0, 1'b1, 8'h81});
        wait_rsp("b2b", 3, 8'h20);
        handshake("b2b");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, observed running expected done");
        $fatal(1, "timeout");
    end

endmodule
